// File: rtl/down_counter_cout.sv
// Loadable down-counter/timer with START/DONE handshake; decrement built as O + ~1 + 1 so COUT is the carry-out.
// Define DOWN_COUNTER_AUTORELOAD_EN to reload the captured period at terminal count instead of stopping.
module down_counter_cout #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             START,
  input  logic [WIDTH-1:0] I,
  input  logic             EN,
  input  logic             ABORT,
  input  logic             ACK,
  output logic [WIDTH-1:0] O,
  output logic             COUT,
  output logic             BUSY,
  output logic             DONE
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] o_nxt;
  logic [WIDTH-1:0] dec;
  logic [WIDTH:0]   sum;
  logic             busy_nxt, done_nxt, reload;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
  logic [WIDTH-1:0] period, period_nxt;
`endif

  // Carry-out is 1 (no borrow) for every O except 0.
  assign sum  = {1'b0, O} + {1'b0, ~ONE} + (WIDTH+1)'(1);
  assign dec  = sum[WIDTH-1:0];
  assign COUT = sum[WIDTH];

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state <= S_IDLE;
      O     <= '0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
      period <= '0;
`endif
    end else begin
      state <= state_nxt;
      O     <= o_nxt;
      BUSY  <= busy_nxt;
      DONE  <= done_nxt;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
      period <= period_nxt;
`endif
    end
  end

  // Priority: ABORT > START > EN > ACK.
  always_comb begin
    state_nxt = state;
    o_nxt     = O;
    reload    = 1'b0;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
    period_nxt = period;
`endif
    if (ABORT) begin
      state_nxt = S_IDLE;
      o_nxt     = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (START) begin
            if (I != '0) begin
              state_nxt = S_RUN;
              o_nxt     = I;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
              period_nxt = I;
`endif
            end else begin
              state_nxt = S_DONE;
              o_nxt     = '0;
            end
          end
        end
        S_RUN: begin
          if (EN) begin
            if (O == ONE) begin
`ifdef DOWN_COUNTER_AUTORELOAD_EN
              o_nxt  = period;
              reload = 1'b1;
`else
              state_nxt = S_DONE;
              o_nxt     = '0;
`endif
            end else begin
              o_nxt = dec;
            end
          end
        end
        S_DONE: begin
          if (ACK) state_nxt = S_IDLE;
        end
        default: begin
          state_nxt = S_IDLE;
          o_nxt     = '0;
        end
      endcase
    end
  end

  always_comb begin
    busy_nxt = (state_nxt == S_RUN);
    done_nxt = (state_nxt == S_DONE) || reload;
  end

endmodule
